d_latch: RTL and testbench



---
 rtl/d_latch.sv | 41 ++++
 tb/tb_d_latch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_latch.sv
// Transparent D latch with a configurable data width, an asynchronous
// active-low reset and a complementary output.
// Optional feature macro: D_LATCH_PARITY_EN adds a 1-bit q_par output that
// carries the XOR reduction of q.
module d_latch #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,    // latch enable: transparent high, opaque low
  input  logic             reset,  // asynchronous, active-low
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
`ifdef D_LATCH_PARITY_EN
  output logic [WIDTH-1:0] qb,
  output logic             q_par
`else
  output logic [WIDTH-1:0] qb
`endif
);

  // Level-sensitive storage: reset overrides the enable, and the enable
  // overrides hold.
  // NOTE: the missing final else is deliberate; always_latch states that
  // a latch is the intended storage element, not an accidental one.
  always_latch begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else if (clk) begin
      q <= d;
    end
  end

  // The complement is derived from q, so it can never disagree with it.
  assign qb = ~q;

`ifdef D_LATCH_PARITY_EN
  // Parity follows q combinationally, including during reset.
  assign q_par = ^q;
`endif

endmodule

// File: tb/tb_d_latch.sv
// Self-checking bench for d_latch: a WIDTH=1 instance (reset value 0) and a
// WIDTH=8 instance (reset value 8'hA5) share the same clk and reset.
// Directed scenarios come first, then a randomized run checked against a
// rule-level reference model.
module tb_d_latch;

  logic       clk;
  logic       reset;
  logic       d;
  logic       q;
  logic       qb;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] qb8;
`ifdef D_LATCH_PARITY_EN
  logic       q_par;
  logic       q8_par;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state for the randomized run.
  logic       m_q;
  logic [7:0] m_q8;

  d_latch #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q),
`ifdef D_LATCH_PARITY_EN
    .qb    (qb),
    .q_par (q_par)
`else
    .qb    (qb)
`endif
  );

  d_latch #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .d     (d8),
    .q     (q8),
`ifdef D_LATCH_PARITY_EN
    .qb    (qb8),
    .q_par (q8_par)
`else
    .qb    (qb8)
`endif
  );

  // Reset asserted: both instances show their reset values no matter what
  // clk and d do, for two full clk periods.
  task automatic test_reset();
    clk   = 1'b0;
    d     = 1'b1;
    d8    = 8'hFF;
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0 || qb !== 1'b1) begin
      errors++;
      $display("FAIL reset_w1: q=%b qb=%b expected q=0 qb=1", q, qb);
    end
    checks++;
    if (q8 !== 8'hA5 || qb8 !== 8'h5A) begin
      errors++;
      $display("FAIL reset_w8: q=%h qb=%h expected q=a5 qb=5a", q8, qb8);
    end
`ifdef D_LATCH_PARITY_EN
    checks++;
    if (q8_par !== 1'b0) begin
      errors++;
      $display("FAIL reset_par: q_par=%b expected 0", q8_par);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      #4 clk = ~clk;
      #1;
      checks++;
      if (q !== 1'b0 || qb !== 1'b1 || q8 !== 8'hA5) begin
        errors++;
        $display("FAIL reset_hold[%0d]: q=%b qb=%b q8=%h expected q=0 qb=1 q8=a5",
                 i, q, qb, q8);
      end
    end
  endtask

  // Transparent phase: q tracks every change of d.
  task automatic test_transparency();
    logic [2:0] seq;
    logic [7:0] seq8 [3];
    seq     = 3'b101;
    seq8[0] = 8'h01;
    seq8[1] = 8'h3C;
    seq8[2] = 8'hFE;
    clk   = 1'b0;
    #1 reset = 1'b1;
    #1 clk   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d  = seq[2-i];
      d8 = seq8[i];
      #1;
      checks++;
      if (q !== seq[2-i] || qb !== ~seq[2-i]) begin
        errors++;
        $display("FAIL transparent[%0d]: q=%b qb=%b expected q=%b", i, q, qb, seq[2-i]);
      end
      checks++;
      if (q8 !== seq8[i] || qb8 !== ~seq8[i]) begin
        errors++;
        $display("FAIL transparent8[%0d]: q=%h qb=%h expected q=%h", i, q8, qb8, seq8[i]);
      end
`ifdef D_LATCH_PARITY_EN
      checks++;
      if (q8_par !== ^seq8[i]) begin
        errors++;
        $display("FAIL transparent_par[%0d]: q_par=%b expected %b", i, q8_par, ^seq8[i]);
      end
`endif
    end
  endtask

  // Opaque phase: the value present at the falling edge is held, and d is
  // ignored until the next rising edge.
  task automatic test_hold();
    reset = 1'b1;
    clk   = 1'b1;
    d     = 1'b1;
    d8    = 8'h96;
    #1 clk = 1'b0;
    #1;
    checks++;
    if (q !== 1'b1 || qb !== 1'b0 || q8 !== 8'h96) begin
      errors++;
      $display("FAIL hold_capture: q=%b qb=%b q8=%h expected q=1 qb=0 q8=96", q, qb, q8);
    end
    d  = 1'b0;
    d8 = 8'h00;
    #1;
    checks++;
    if (q !== 1'b1 || qb !== 1'b0 || q8 !== 8'h96) begin
      errors++;
      $display("FAIL hold_ignore_d: q=%b qb=%b q8=%h expected q=1 qb=0 q8=96", q, qb, q8);
    end
    #1 clk = 1'b1;
    #1;
    checks++;
    if (q !== 1'b0 || qb !== 1'b1 || q8 !== 8'h00) begin
      errors++;
      $display("FAIL hold_reopen: q=%b qb=%b q8=%h expected q=0 qb=1 q8=00", q, qb, q8);
    end
  endtask

  // Reset pulled during a transparent phase, then released with clk high
  // (q takes d at once) and again with clk low (q keeps the reset value).
  task automatic test_async_reset();
    clk   = 1'b1;
    reset = 1'b1;
    d     = 1'b1;
    d8    = 8'h3B;
    #1;
    checks++;
    if (q !== 1'b1 || q8 !== 8'h3B) begin
      errors++;
      $display("FAIL async_pre: q=%b q8=%h expected q=1 q8=3b", q, q8);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0 || qb !== 1'b1 || q8 !== 8'hA5) begin
      errors++;
      $display("FAIL async_assert: q=%b qb=%b q8=%h expected q=0 qb=1 q8=a5", q, qb, q8);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (q !== 1'b1 || qb !== 1'b0 || q8 !== 8'h3B) begin
      errors++;
      $display("FAIL async_release_high: q=%b qb=%b q8=%h expected q=1 qb=0 q8=3b",
               q, qb, q8);
    end
    reset = 1'b0;
    #1 clk = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (q !== 1'b0 || q8 !== 8'hA5) begin
      errors++;
      $display("FAIL async_release_low: q=%b q8=%h expected q=0 q8=a5", q, q8);
    end
    #1 clk = 1'b1;
    #1;
    checks++;
    if (q !== 1'b1 || q8 !== 8'h3B) begin
      errors++;
      $display("FAIL async_next_open: q=%b q8=%h expected q=1 q8=3b", q, q8);
    end
    #1 clk = 1'b0;
  endtask

  // Free-running clock of period 10 with the reset/d schedule of the
  // reference timeline; expectations come from a piecewise description of
  // the inputs over time.
  task automatic test_periodic();
    logic held;
    held = 1'b0;
    fork
      begin
        clk = 1'b0;
        for (int i = 0; i < 12; i++) #5 clk = ~clk;
      end
      begin
        reset = 1'b1;
        d     = 1'b1;
        #5  reset = 1'b0;
        #5  d     = 1'b0;
        #10 d     = 1'b1;
        #20 reset = 1'b1;
      end
      begin
        #7;
        for (int k = 1; k < 12; k++) begin
          int  t;
          logic e_rst;
          logic e_d;
          logic e_clk;
          t     = 5 * k + 2;
          e_rst = (t < 5 || t >= 40);
          e_d   = (t < 10 || t >= 20);
          e_clk = ((t / 5) % 2) == 1;
          if (!e_rst)     held = 1'b0;
          else if (e_clk) held = e_d;
          checks++;
          if (q !== held || qb !== ~held) begin
            errors++;
            $display("FAIL periodic_t%0d: q=%b qb=%b expected q=%b", t, q, qb, held);
          end
          #5;
        end
      end
    join
    clk = 1'b0;
  endtask

  // Reference model: applies the priority rules to the current input levels.
  task automatic model_update();
    if (!reset) begin
      m_q  = 1'b0;
      m_q8 = 8'hA5;
    end else if (clk) begin
      m_q  = d;
      m_q8 = d8;
    end
  endtask

  // Randomized sequence of single-input changes compared against the model.
  task automatic test_random();
    reset = 1'b0;
    clk   = 1'b0;
    #1;
    model_update();
    reset = 1'b1;
    #1;
    model_update();
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        reset = reset ? ($urandom_range(0, 2) != 0) : 1'b1;
      end else if (sel <= 4) begin
        clk = ~clk;
      end else begin
        d  = 1'($urandom);
        d8 = 8'($urandom);
      end
      model_update();
      #1;
      checks++;
      if (q !== m_q || qb !== ~m_q) begin
        errors++;
        $display("FAIL random_w1[%0d]: q=%b qb=%b expected q=%b", i, q, qb, m_q);
      end
      checks++;
      if (q8 !== m_q8 || qb8 !== ~m_q8) begin
        errors++;
        $display("FAIL random_w8[%0d]: q=%h qb=%h expected q=%h", i, q8, qb8, m_q8);
      end
`ifdef D_LATCH_PARITY_EN
      checks++;
      if (q8_par !== ^m_q8 || q_par !== m_q) begin
        errors++;
        $display("FAIL random_par[%0d]: q_par=%b q8_par=%b expected %b %b",
                 i, q_par, q8_par, m_q, ^m_q8);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_transparency();
    test_hold();
    test_async_reset();
    test_periodic();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
